// File: rtl/vec_load_writeback.sv
// vec_load_writeback: gathers LANES consecutive 32-bit memory words into one
// 128-bit vector and writes it to a vector register file in a single strobe.
// Optional feature macro: VLW_TIMEOUT_EN (per-lane wait limit of TIMEOUT cycles,
// err pulse and abort on expiry). Without it, REQ waits indefinitely.
//
// Memory handshake: while mem_rd is high, mem_addr is stable; a lane is
// transferred on the rising edge where mem_rd and mem_valid are both high.
// mem_valid is ignored whenever mem_rd is low.
module vec_load_writeback #(
    parameter int LANE_W  = 32,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [4:0]        rd_in,
    output logic              mem_rd,
    output logic [31:0]       mem_addr,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              WriteEn,
    output logic [4:0]        rd,
    output logic [127:0]      InputData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(LANES - 1);

    if (LANE_W * LANES != 128 || TIMEOUT < 1) begin : g_bad_cfg
        $error("vec_load_writeback: LANE_W*LANES must be 128 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [LANE_CW-1:0]   lane_q;
    logic [31:0]          base_q;
    logic [4:0]           rd_q;
    logic [127:0]         vec_q;
    logic [127:0]         vec_next;
    logic [127:0]         out_q;
    logic                 timeout;
    logic                 capture;

`ifdef VLW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q;

    assign timeout = (state == S_REQ) && (wait_q == CNT_W'(TIMEOUT));

    // Per-lane wait counter: idle outside REQ, restarts on every captured lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state != S_REQ || mem_valid) begin
            wait_q <= '0;
        end else if (!timeout) begin
            wait_q <= wait_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A lane is accepted only while the request is actually being driven.
    assign capture   = (state == S_REQ) && !timeout && mem_valid;
    assign mem_addr  = (state == S_REQ) ? base_q + {{(30 - LANE_CW){1'b0}}, lane_q, 2'b00} : 32'h0;
    assign rd        = rd_q;
    assign InputData = out_q;
    assign dbg_state = state;

    // Insert the incoming word into the slot of the current lane.
    always_comb begin
        vec_next = vec_q;
        vec_next[int'(lane_q) * LANE_W +: LANE_W] = mem_rdata;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        WriteEn    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (timeout) begin
                    err        = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_valid && lane_q == LAST_LANE) begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                WriteEn    = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, lane counter and vector assembly; the output vector only
    // changes when a complete load finishes, so it holds across IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= 32'h0;
            rd_q   <= 5'h0;
            lane_q <= '0;
            vec_q  <= '0;
            out_q  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q <= base_addr;
                rd_q   <= rd_in;
                lane_q <= '0;
                vec_q  <= '0;
            end else if (capture) begin
                vec_q <= vec_next;
                if (lane_q == LAST_LANE) begin
                    out_q <= vec_next;
                end else begin
                    lane_q <= lane_q + LANE_CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_load_writeback.sv
// Bench for vec_load_writeback: directed loads against a queue-based model of
// addresses, returned words, register writes and write latency.
module tb_vec_load_writeback;

    localparam int LANE_W  = 32;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [31:0]       base_addr;
    logic [4:0]        rd_in;
    logic              mem_rd;
    logic [31:0]       mem_addr;
    logic [LANE_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              WriteEn;
    logic [4:0]        rd;
    logic [127:0]      InputData;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        dbg_state;

    vec_load_writeback #(.LANE_W(LANE_W), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .rd_in(rd_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .WriteEn(WriteEn), .rd(rd), .InputData(InputData),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_edge = 0;
    int last_lat = -1;
    int writes_seen = 0;
    int done_seen = 0;
    int err_seen = 0;
    int wait_n = 0;
    bit hold_resp = 0;
    bit prev_err = 0;

    logic [31:0]  exp_addr_q[$];
    logic [31:0]  rdata_q[$];
    logic [132:0] exp_wr_q[$];
    int           exp_lat_q[$];
    logic [31:0]  seen_addr_q[$];
    logic [31:0]  lit_addr[4];

`ifdef VLW_TIMEOUT_EN
    bit to_armed = 0;
    int to_cyc = 0;
`endif

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: what one load must produce, from addresses and words alone.
    task automatic queue_load(input logic [31:0] base, input logic [4:0] rdi, input logic [127:0] vec);
        for (int i = 0; i < LANES; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            rdata_q.push_back(vec[32 * i +: 32]);
        end
        exp_wr_q.push_back({rdi, vec});
        exp_lat_q.push_back(LANES * (wait_n + 1));
    endtask

    task automatic start_load(input logic [31:0] base, input logic [4:0] rdi);
        @(negedge clk);
        base_addr = base;
        rd_in     = rdi;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_edge = cyc;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {159'b0, busy}, 160'd0);
    endtask

    // Memory responder: wait_n idle cycles, then the next queued word.
    initial begin : responder
        int wc;
        logic [31:0] tmp;
        wc = 0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (rdata_q.size() > 0) tmp = rdata_q.pop_front();
                wc = 0;
            end
            mem_valid = 1'b0;
            if (mem_rd === 1'b1 && !hold_resp && !rst) begin
                if (wc >= wait_n && rdata_q.size() > 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = rdata_q[0];
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Compare process: every cycle outside reset.
    initial begin : compare
        logic [132:0] wr;
        int lat;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (prev_err) check("busy_after_err", {159'b0, busy}, 160'd0);
                prev_err = (err === 1'b1);
                if (mem_rd === 1'b1) begin
                    check("busy_in_req", {159'b0, busy}, 160'd1);
                    if (exp_addr_q.size() == 0) begin
                        check("mem_rd_unexpected", {159'b0, mem_rd}, 160'd0);
                    end else begin
                        check("mem_addr", {128'b0, mem_addr}, {128'b0, exp_addr_q[0]});
                        if (mem_valid) begin
                            seen_addr_q.push_back(mem_addr);
                            exp_addr_q.pop_front();
                        end
                    end
                end
                if (done === 1'b1) done_seen++;
                if (WriteEn === 1'b1) begin
                    writes_seen++;
                    check("done_with_write", {159'b0, done}, 160'd1);
                    if (exp_wr_q.size() == 0) begin
                        check("write_unexpected", {159'b0, WriteEn}, 160'd0);
                    end else begin
                        wr  = exp_wr_q.pop_front();
                        lat = exp_lat_q.pop_front();
                        last_lat = cyc - start_edge;
                        check("write_rd_data", {27'b0, rd, InputData}, {27'b0, wr});
                        check("write_latency", 160'(last_lat), 160'(lat));
                    end
                end
                if (err === 1'b1) err_seen++;
`ifdef VLW_TIMEOUT_EN
                check("err", {159'b0, err}, {159'b0, (to_armed && cyc == to_cyc)});
`else
                check("err_low", {159'b0, err}, 160'd0);
`endif
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"}, {159'b0, mem_rd}, 160'd0);
        check({tag, "_we"}, {159'b0, WriteEn}, 160'd0);
        check({tag, "_done"}, {159'b0, done}, 160'd0);
        check({tag, "_err"}, {159'b0, err}, 160'd0);
        check({tag, "_busy"}, {159'b0, busy}, 160'd0);
        check({tag, "_rd"}, {155'b0, rd}, 160'd0);
        check({tag, "_addr"}, {128'b0, mem_addr}, 160'd0);
        check({tag, "_data"}, {32'b0, InputData}, 160'd0);
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_addr_count"}, 160'(seen_addr_q.size()), 160'd4);
        for (int i = 0; i < 4 && i < seen_addr_q.size(); i++) begin
            check({tag, "_addr_lit"}, {128'b0, seen_addr_q[i]}, {128'b0, lit_addr[i]});
        end
    endtask

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        rd_in = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait load with literal expectations.
        wait_n = 0;
        seen_addr_q.delete();
        queue_load(32'h100, 5'd3, 128'h44444444_33333333_22222222_11111111);
        start_load(32'h100, 5'd3);
        wait_idle(50);
        lit_addr[0] = 32'h100; lit_addr[1] = 32'h104; lit_addr[2] = 32'h108; lit_addr[3] = 32'h10C;
        check_addrs("zw");
        check("zw_latency_lit", 160'(last_lat), 160'd4);
        check("zw_data_held", {32'b0, InputData}, {32'b0, 128'h44444444_33333333_22222222_11111111});
        check("zw_rd_held", {155'b0, rd}, 160'd3);
        check("zw_writes", 160'(writes_seen), 160'd1);

        // Two wait states before every word.
        wait_n = 2;
        queue_load(32'h2000, 5'd7, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678);
        start_load(32'h2000, 5'd7);
        wait_idle(100);
        check("ws_latency_lit", 160'(last_lat), 160'd12);
        check("ws_writes", 160'(writes_seen), 160'd2);
        check("ws_done", 160'(done_seen), 160'd2);

        // start held during a busy load with different operands.
        wait_n = 1;
        queue_load(32'h300, 5'd9, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
        start_load(32'h300, 5'd9);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            start     = 1'b1;
            rd_in     = 5'(20 + n);
            base_addr = 32'hDEAD0000;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("nb_stay_idle", {159'b0, busy}, 160'd0);
        end
        check("nb_rd_first", {155'b0, rd}, 160'd9);
        check("nb_writes", 160'(writes_seen), 160'd3);

        // Reset after lane 2 capture aborts the load.
        wait_n = 0;
        queue_load(32'h400, 5'd11, 128'h01010101_02020202_03030303_04040404);
        start_load(32'h400, 5'd11);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_addr_q.delete();
        rdata_q.delete();
        exp_wr_q.delete();
        exp_lat_q.delete();
        repeat (2) @(negedge clk);
        check("abort_no_write", 160'(writes_seen), 160'd3);
        queue_load(32'h500, 5'd12, 128'h55555555_66666666_77777777_88888888);
        start_load(32'h500, 5'd12);
        wait_idle(50);
        check("after_abort_writes", 160'(writes_seen), 160'd4);

        // Address wrap across 2^32, rd_in upper bits passed through.
        seen_addr_q.delete();
        queue_load(32'hFFFFFFF8, 5'd31, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);
        start_load(32'hFFFFFFF8, 5'd31);
        wait_idle(50);
        lit_addr[0] = 32'hFFFFFFF8; lit_addr[1] = 32'hFFFFFFFC; lit_addr[2] = 32'h0; lit_addr[3] = 32'h4;
        check_addrs("wrap");
        check("wrap_rd", {155'b0, rd}, 160'd31);
        check("wrap_writes", 160'(writes_seen), 160'd5);

`ifdef VLW_TIMEOUT_EN
        // Memory never answers: err after TIMEOUT cycles in REQ.
        hold_resp = 1;
        exp_addr_q.push_back(32'h600);
        to_armed = 1;
        start_load(32'h600, 5'd1);
        to_cyc = start_edge + TIMEOUT;
        wait_idle(40);
        repeat (2) @(negedge clk);
        check("to_err_pulses", 160'(err_seen), 160'd1);
        check("to_no_write", 160'(writes_seen), 160'd5);
        to_armed = 0;
        hold_resp = 0;
        exp_addr_q.delete();
`else
        check("no_err_seen", 160'(err_seen), 160'd0);
`endif

        repeat (2) @(negedge clk);
        check("done_total", 160'(done_seen), 160'd5);
        check("wr_q_empty", 160'(exp_wr_q.size()), 160'd0);
        check("addr_q_empty", 160'(exp_addr_q.size()), 160'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_load_writeback.md
VEC_LOAD_WRITEBACK -- requirements
Module: vec_load_writeback

Interface
REQ-001 Parameter LANE_W, default 32, memory word and vector lane width in bits.
REQ-002 Parameter LANES, default 4, lanes per vector; LANE_W*LANES SHALL equal 128.
REQ-003 Parameter TIMEOUT, default 64, maximum wait cycles per lane; used only under VLW_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request one vector load; sampled only in IDLE.
REQ-007 base_addr  input  32  byte address of lane 0; latched on accepted start.
REQ-008 rd_in  input  5  destination vector register; latched on accepted start.
REQ-009 mem_rd  output  1  memory read request.
REQ-010 mem_addr  output  32  request address, equal to base + 4*lane.
REQ-011 mem_rdata  input  LANE_W  read data; valid when mem_valid is high.
REQ-012 mem_valid  input  1  read data valid; ignored while mem_rd is low.
REQ-013 WriteEn  output  1  register-file write strobe.
REQ-014 rd  output  5  register-file write index.
REQ-015 InputData  output  128  register-file write data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  one-cycle timeout pulse; tied low without VLW_TIMEOUT_EN.

Function
REQ-019 FSM states: IDLE, REQ, WRITE; an encoding outside these three SHALL return to IDLE.
REQ-020 IDLE with start=1 at an edge -> latch base_addr and rd_in, clear lane counter to 0, go to REQ.
REQ-021 In REQ, mem_rd=1 and mem_addr=base+(lane<<2); both held stable until mem_valid=1 is sampled.
REQ-022 mem_valid=1 in REQ -> mem_rdata captured into bits [lane*LANE_W +: LANE_W] and lane incremented; lane 0 occupies bits [31:0].
REQ-023 Capture of lane LANES-1 -> WRITE; no wrap of the lane counter inside one load.
REQ-024 In WRITE, WriteEn=1, done=1, rd=latched rd_in and InputData=assembled vector for exactly one cycle, then IDLE.
REQ-025 Zero-wait memory: start sampled at edge k -> WriteEn high between edges k+LANES and k+LANES+1.
REQ-026 start while busy SHALL be ignored, with no queuing and no change to latched operands.
REQ-027 Address arithmetic SHALL be modulo 2^32 (0xFFFFFFFC + 4 wraps to 0x00000000).
REQ-028 WriteEn, mem_rd, done and err SHALL be low in IDLE; InputData holds its last value.
REQ-029 rd_in bits [4:3] are passed through unmodified; range checking belongs to the register file.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, lane=0, mem_rd=0, WriteEn=0, done=0, err=0, busy=0, rd=0, mem_addr=0 and InputData=0.
REQ-031 Reset asserted mid-load SHALL abort the load with no WriteEn pulse, and partial data SHALL be discarded.

Configuration
REQ-032 Macro VLW_TIMEOUT_EN defined: a per-lane wait counter is cleared on entering REQ and on each capture.
REQ-033 With VLW_TIMEOUT_EN, when the counter reaches TIMEOUT without mem_valid, the block SHALL pulse err for one cycle, drop mem_rd, return to IDLE and issue no WriteEn.
REQ-034 Macro VLW_TIMEOUT_EN undefined: no counter is present, REQ waits indefinitely and err is constant 0.

Verification
REQ-035 Zero-wait load: base=0x100, rd_in=3, words 0x11111111/0x22222222/0x33333333/0x44444444 -> mem_addr 0x100/0x104/0x108/0x10C; WriteEn=1 with rd=3 and InputData=0x44444444_33333333_22222222_11111111, arriving 4 cycles after start.
REQ-036 Wait states: 2 idle cycles before each mem_valid -> mem_addr held stable during waits; WriteEn 12 cycles after start; done pulses once.
REQ-037 start asserted every cycle during a load with a different rd_in -> a single write using the first rd_in; the next load starts only after return to IDLE.
REQ-038 rst pulsed after lane 2 capture -> no WriteEn; all outputs 0; a following load completes normally.
REQ-039 base=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-040 VLW_TIMEOUT_EN with TIMEOUT=8 and mem_valid withheld -> err pulse 8 cycles into REQ, busy=0 next cycle, no WriteEn.
